data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, default 64: data word width in bits; SHALL be 64 (LEGv8 doubleword).
REQ-002 Parameter DEPTH, default 32: number of DATA_W words; power of two, 2..1024.
REQ-003 Parameter WAIT_CYCLES, default 0: extra access wait states, 0..7.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  access request present.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 write_en  input  1  1 = store, 0 = load; sampled with the request.
REQ-009 size  input  2  access size: 0 byte, 1 half, 2 word, 3 doubleword.
REQ-010 address  input  64  byte address.
REQ-011 data_in  input  DATA_W  store data, right-aligned.
REQ-012 rsp_valid  output  1  one-cycle pulse: access complete.
REQ-013 out  output  DATA_W  load data, zero-extended, right-aligned; held until the next load response.
REQ-014 fault  output  1  valid with rsp_valid: misaligned or out-of-range access.
REQ-015 busy  output  1  initialisation sweep in progress.

Function
REQ-016 A request SHALL be accepted when req_valid and req_ready are both high; the block SHALL register write_en, size, address and data_in on acceptance.
REQ-017 FSM states: IDLE, WAIT, RESP, plus INIT when configured; req_ready SHALL be high only in IDLE.
REQ-018 IDLE->WAIT on acceptance if WAIT_CYCLES>0, else IDLE->RESP; WAIT SHALL count WAIT_CYCLES cycles, then go to RESP; RESP->IDLE after one cycle.
REQ-019 rsp_valid SHALL be high exactly in the RESP cycle; latency from acceptance to rsp_valid SHALL be WAIT_CYCLES+1 cycles.
REQ-020 Word index SHALL be address[log2(DEPTH)+2:3]; byte lane SHALL be address[2:0].
REQ-021 Misaligned: address[size-1:0] nonzero (none for bytes); out of range: address >= DEPTH*8; either SHALL raise fault in RESP.
REQ-022 A faulting store SHALL NOT modify memory; a faulting load SHALL leave out unchanged.
REQ-023 Stores SHALL write only the addressed 1/2/4/8 bytes, with byte enables, in the RESP cycle; other bytes SHALL be preserved.
REQ-024 Loads SHALL return the addressed bytes, zero-extended, on out in the RESP cycle.
REQ-025 A request arriving in WAIT or RESP SHALL be held off (req_ready low) and not lost; back-to-back accesses SHALL achieve one access per WAIT_CYCLES+2 cycles.
REQ-026 A load following a store to the same address SHALL return the stored data.

Reset
REQ-027 On reset: state IDLE (or INIT when configured), rsp_valid 0, fault 0, out 0, busy 0 (1 when INIT), wait counter 0.
REQ-028 Reset mid-access SHALL abort it: no memory write, no rsp_valid.
REQ-029 Memory contents SHALL NOT be cleared by reset unless configured.

Configuration
REQ-030 Macro DATA_MEMORY_INIT_EN defined: reset SHALL enter INIT, write word i = i*100 for i = 0..DEPTH-1 at one word per cycle, hold busy high and req_ready low, then go to IDLE; the sweep takes DEPTH cycles.
REQ-031 Macro undefined: no INIT state, busy tied 0, contents undefined until written.

Structure
REQ-032 Shared package dmem_pkg SHALL hold the size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD) and the FSM state type.
REQ-033 One sub-module, dmem_lane_ctrl: combinational byte-enable, store alignment and load extraction from size and address[2:0].

Verification
REQ-034 Load doubleword addr 0x18, WAIT_CYCLES=0, INIT_EN -> rsp_valid after 1 cycle, out=300, fault=0.
REQ-035 Store byte 0xAB to addr 0x09 over word 1=100, then load dword 0x08 -> out=0x000000000000AB64.
REQ-036 Load half addr 0x03 -> fault=1, out unchanged; store word addr 0x100 (DEPTH=32) -> fault=1, memory unchanged.
REQ-037 WAIT_CYCLES=3, back-to-back loads with req_valid held -> req_ready low 4 cycles per access, rsp_valid 4 cycles after each acceptance.
REQ-038 Assert reset in WAIT of a store to 0x10 -> no rsp_valid; after INIT, load 0x10 -> out=200.
REQ-039 After reset with INIT_EN -> busy high exactly DEPTH cycles, req_ready low throughout.

Source files
------------

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: access size encodings, FSM state type and lane helpers shared by the data memory
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_INIT} state_t;

    function automatic logic [7:0] size_bytes_mask(input logic [1:0] size);
        return size == SZ_BYTE ? 8'h01 : size == SZ_HALF ? 8'h03 : size == SZ_WORD ? 8'h0f : 8'hff;
    endfunction

    function automatic logic [2:0] align_mask(input logic [1:0] size);
        return (3'd1 << size) - 3'd1;
    endfunction
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: request/response bus of the data memory
interface data_memory_if #(parameter int DATA_W = 64);
    logic              req_valid;
    logic              req_ready;
    logic              write_en;
    logic [1:0]        size;
    logic [63:0]       address;
    logic [DATA_W-1:0] data_in;
    logic              rsp_valid;
    logic [DATA_W-1:0] out;
    logic              fault;
    logic              busy;

    modport master(output req_valid, write_en, size, address, data_in,
                   input req_ready, rsp_valid, out, fault, busy);
    modport slave(input req_valid, write_en, size, address, data_in,
                  output req_ready, rsp_valid, out, fault, busy);
endinterface

// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: byte enables, store alignment and zero-extended load extraction for one doubleword
module dmem_lane_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]          size,
    input  logic [2:0]          lane,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W-1:0]   rd_data,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   ld_data
);
    localparam int NB = DATA_W / 8;

    logic [7:0]        bm;
    logic [DATA_W-1:0] shifted;

    // shift store data up to its lane, shift load data down and mask off bytes beyond the access size
    always_comb begin
        bm = size_bytes_mask(size);
        be = NB'(bm) << lane;
        wr_data = store_data << {lane, 3'b000};
        shifted = rd_data >> {lane, 3'b000};
        ld_data = '0;
        for (int i = 0; i < NB; i++) ld_data[i*8 +: 8] = bm[i] ? shifted[i*8 +: 8] : 8'h00;
    end
endmodule

// File: rtl/data_memory.sv
// data_memory: LEGv8 doubleword data memory with wait states; DATA_MEMORY_INIT_EN adds a reset-time i*100 fill sweep
module data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input logic         clk,
    input logic         reset,
    data_memory_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] LAST_WAIT = 3'(WAIT_CYCLES - 1);

    state_t            state, state_n;
    logic [2:0]        cnt;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [63:0]       addr_q;
    logic [DATA_W-1:0] din_q, out_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     idx;
    logic              fault_c, commit;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0] wdata, ldata, rdata;
`ifdef DATA_MEMORY_INIT_EN
    logic [AW-1:0]     ptr;
`endif

    assign idx     = addr_q[AW+2:3];
    assign rdata   = mem[idx];
    assign fault_c = |(addr_q[2:0] & align_mask(size_q)) || addr_q >= 64'(DEPTH * 8);
    assign commit  = state == ST_RESP && !fault_c && !reset;

    dmem_lane_ctrl #(.DATA_W(DATA_W)) u_lane (
        .size(size_q),
        .lane(addr_q[2:0]),
        .store_data(din_q),
        .rd_data(rdata),
        .be(be),
        .wr_data(wdata),
        .ld_data(ldata)
    );

    // state register and wait-state counter; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef DATA_MEMORY_INIT_EN
            state <= ST_INIT;
`else
            state <= ST_IDLE;
`endif
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= (state == ST_WAIT && state_n == ST_WAIT) ? cnt + 3'd1 : '0;
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (bus.req_valid) state_n = WAIT_CYCLES > 0 ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt == LAST_WAIT) state_n = ST_RESP;
            ST_RESP: state_n = ST_IDLE;
`ifdef DATA_MEMORY_INIT_EN
            ST_INIT: if (ptr == AW'(DEPTH - 1)) state_n = ST_IDLE;
`else
            ST_INIT: state_n = ST_IDLE;
`endif
        endcase
    end

    // capture the request when it is accepted
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.req_valid) begin
            wr_q   <= bus.write_en;
            size_q <= bus.size;
            addr_q <= bus.address;
            din_q  <= bus.data_in;
        end
    end

    // load result is held between load responses; faulting loads leave it alone
    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else if (commit && !wr_q) out_q <= ldata;
    end

`ifdef DATA_MEMORY_INIT_EN
    // sweep pointer for the reset-time fill
    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (state == ST_INIT) ptr <= ptr + 1'b1;
    end
`endif

    // memory array: fill sweep writes whole words, stores write only their enabled bytes
    always_ff @(posedge clk) begin
`ifdef DATA_MEMORY_INIT_EN
        if (!reset && state == ST_INIT) mem[ptr] <= DATA_W'(ptr) * DATA_W'(100);
`endif
        if (commit && wr_q)
            for (int i = 0; i < DATA_W / 8; i++)
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end

    assign bus.req_ready = state == ST_IDLE;
    assign bus.rsp_valid = state == ST_RESP;
    assign bus.fault     = state == ST_RESP && fault_c;
    assign bus.out       = (state == ST_RESP && !wr_q && !fault_c) ? ldata : out_q;
`ifdef DATA_MEMORY_INIT_EN
    assign bus.busy      = state == ST_INIT;
`else
    assign bus.busy      = 1'b0;
`endif
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed table-driven checks of data_memory with zero and three wait states
module tb_data_memory;
    import dmem_pkg::*;

`ifdef DATA_MEMORY_INIT_EN
    localparam int   BUSY_EXP = 32;
    localparam logic INIT_EXP = 1'b1;
`else
    localparam int   BUSY_EXP = 0;
    localparam logic INIT_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst3, sel, rv, we;
    logic [1:0]  sz;
    logic [63:0] addr, din;
    logic        rdy, rsp, flt, bsy;
    logic [63:0] dout;
    int errs = 0;
    int checks = 0;

    data_memory_if #(.DATA_W(64)) b0();
    data_memory_if #(.DATA_W(64)) b3();

    assign b0.req_valid = rv & ~sel;
    assign b0.write_en  = we;
    assign b0.size      = sz;
    assign b0.address   = addr;
    assign b0.data_in   = din;
    assign b3.req_valid = rv & sel;
    assign b3.write_en  = we;
    assign b3.size      = sz;
    assign b3.address   = addr;
    assign b3.data_in   = din;

    assign rdy  = sel ? b3.req_ready : b0.req_ready;
    assign rsp  = sel ? b3.rsp_valid : b0.rsp_valid;
    assign flt  = sel ? b3.fault     : b0.fault;
    assign bsy  = sel ? b3.busy      : b0.busy;
    assign dout = sel ? b3.out       : b0.out;

    data_memory #(.DATA_W(64), .DEPTH(32), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset(rst0), .bus(b0));
    data_memory #(.DATA_W(64), .DEPTH(32), .WAIT_CYCLES(3)) u3 (.clk(clk), .reset(rst3), .bus(b3));

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] eo;
        logic        ef;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic [1:0] s, input logic [63:0] a, input logic [63:0] d,
                          output logic [63:0] o, output logic f, output int lat);
        int g;
        @(negedge clk);
        we = w; sz = s; addr = a; din = d; rv = 1'b1;
        g = 0;
        while (!rdy && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1 rv = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (rsp) break;
        end
        o = dout;
        f = flt;
    endtask

    task automatic do_reset(input logic s3, input logic pre);
        int n;
        int l;
        logic [63:0] o;
        logic f;
        sel = s3;
        if (s3) rst3 = 1'b1; else rst0 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rsp", 64'(rsp), 64'd0);
        end
        chk("rst_out", dout, 64'd0);
        chk("rst_fault", 64'(flt), 64'd0);
        chk("rst_busy", 64'(bsy), 64'(INIT_EXP));
        if (s3) rst3 = 1'b0; else rst0 = 1'b0;
        n = 0;
        while (bsy && n < 200) begin
            chk("init_ready", 64'(rdy), 64'd0);
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'(BUSY_EXP));
        chk("idle_ready", 64'(rdy), 64'd1);
`ifndef DATA_MEMORY_INIT_EN
        if (pre)
            for (int i = 0; i < 32; i++) access(1'b1, SZ_DWORD, 64'(i * 8), 64'(i * 100), o, f, l);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] o;
        logic f;
        int l;
        rv = 0; sel = 0; we = 0; sz = 0; addr = 0; din = 0; rst0 = 0; rst3 = 0;
        tbl[0]  = '{1'b0, SZ_DWORD, 64'h18, 64'h0, 64'd300, 1'b0};
        tbl[1]  = '{1'b1, SZ_BYTE,  64'h09, 64'hAB, 64'd300, 1'b0};
        tbl[2]  = '{1'b0, SZ_DWORD, 64'h08, 64'h0, 64'hAB64, 1'b0};
        tbl[3]  = '{1'b0, SZ_HALF,  64'h03, 64'h0, 64'hAB64, 1'b1};
        tbl[4]  = '{1'b1, SZ_WORD,  64'h100, 64'hDEADBEEF, 64'hAB64, 1'b1};
        tbl[5]  = '{1'b0, SZ_DWORD, 64'h00, 64'h0, 64'h0, 1'b0};
        tbl[6]  = '{1'b0, SZ_BYTE,  64'h09, 64'h0, 64'hAB, 1'b0};
        tbl[7]  = '{1'b1, SZ_DWORD, 64'h20, 64'h1122334455667788, 64'hAB, 1'b0};
        tbl[8]  = '{1'b0, SZ_WORD,  64'h24, 64'h0, 64'h11223344, 1'b0};
        tbl[9]  = '{1'b0, SZ_HALF,  64'h22, 64'h0, 64'h5566, 1'b0};
        tbl[10] = '{1'b1, SZ_HALF,  64'h26, 64'hFFFFBEEF, 64'h5566, 1'b0};
        tbl[11] = '{1'b0, SZ_DWORD, 64'h20, 64'h0, 64'hBEEF334455667788, 1'b0};
        tbl[12] = '{1'b0, SZ_WORD,  64'h22, 64'h0, 64'hBEEF334455667788, 1'b1};
        tbl[13] = '{1'b0, SZ_DWORD, 64'hF8, 64'h0, 64'hC1C, 1'b0};
        tbl[14] = '{1'b0, SZ_BYTE,  64'hFF, 64'h0, 64'h0, 1'b0};
        tbl[15] = '{1'b0, SZ_BYTE,  64'h100, 64'h0, 64'h0, 1'b1};
        tbl[16] = '{1'b1, SZ_DWORD, 64'h0C, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1};
        tbl[17] = '{1'b0, SZ_DWORD, 64'h08, 64'h0, 64'hAB64, 1'b0};
        tbl[18] = '{1'b0, SZ_DWORD, 64'h8000000000000008, 64'h0, 64'hAB64, 1'b1};
        tbl[19] = '{1'b0, SZ_WORD,  64'h18, 64'h0, 64'h12C, 1'b0};

        do_reset(1'b0, 1'b1);
        do_reset(1'b1, 1'b1);

        sel = 0;
        foreach (tbl[i]) begin
            access(tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].d, o, f, l);
            chk($sformatf("vec%0d_out", i), o, tbl[i].eo);
            chk($sformatf("vec%0d_fault", i), 64'(f), 64'(tbl[i].ef));
            chk($sformatf("vec%0d_latency", i), 64'(l), 64'd1);
        end

        @(negedge clk);
        sel = 1; we = 0; sz = SZ_DWORD; addr = 64'h18; din = 0; rv = 1;
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("b2b_ready_c%0d", c), 64'(rdy), 64'(c % 5 == 0));
            chk($sformatf("b2b_rsp_c%0d", c), 64'(rsp), 64'(c % 5 == 4));
            if (c % 5 == 4) chk($sformatf("b2b_out_c%0d", c), dout, 64'd300);
            @(negedge clk);
        end
        rv = 0;

        @(negedge clk);
        sel = 1; we = 1; sz = SZ_DWORD; addr = 64'h10; din = 64'h999; rv = 1;
        @(posedge clk);
        #1 rv = 0;
        @(negedge clk);
        chk("abort_in_wait", 64'(rdy), 64'd0);
        do_reset(1'b1, 1'b0);
        access(1'b0, SZ_DWORD, 64'h10, 64'h0, o, f, l);
        chk("abort_mem", o, 64'd200);
        chk("abort_fault", 64'(f), 64'd0);
        chk("wait3_latency", 64'(l), 64'd4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
